mips_multicycle_control: RTL and testbench

Multicycle control unit that drives the datapath control lines (`ALUControl`, `RegWrite`, `MemWrite`) currently supplied externally to the single-cycle top level. It decodes the opcode/funct of the fetched instruction and sequences fetch, decode, execute, memory and write-back states, one state per clock. It sits beside the datapath and replaces the hand-driven control inputs at the top level.

---
 rtl/mips_multicycle_control.sv | 215 +++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back and drives datapath strobes.
// Optional beq support is enabled by defining MC_BRANCH_EN; otherwise opcode 000100 decodes as illegal.
module mips_multicycle_control #(
  parameter int ALU_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero_flag,
  output logic [ALU_W-1:0] ALUControl,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             retire,
  output logic             illegal
);

`ifdef MC_BRANCH_EN
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH
  } state_t;
`else
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_IMMEX, S_IMMWB
  } state_t;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_BRANCH_EN
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b010);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b110);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b000);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b001);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b111);

  state_t           state_reg, state_next;
  logic [ALU_W-1:0] alu_op_reg, alu_op_next;
  logic             is_lw_reg, is_lw_next;

  logic [ALU_W-1:0] funct_alu;
  logic             funct_ok;
  logic             fetch_accept;

`ifndef MC_BRANCH_EN
  // zero_flag only matters to the branch path
  logic unused_zero;
  assign unused_zero = zero_flag;
`endif

  // Fetch is also suppressed while reset is held so no IR/PC load leaks out.
  assign fetch_accept = instr_valid && rst_n;

  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_FETCH;
      alu_op_reg <= ALU_ADD;
      is_lw_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      alu_op_reg <= alu_op_next;
      is_lw_reg  <= is_lw_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    alu_op_next = alu_op_reg;
    is_lw_next  = is_lw_reg;
    ALUControl  = '0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    ALUSrc      = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        if (fetch_accept) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // ALU op and lw/sw choice are latched here so later states need not re-decode.
        alu_op_next = funct_alu;
        is_lw_next  = (opcode == OP_LW);
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_next = S_EXEC;
            end else begin
              illegal    = 1'b1;
              state_next = S_FETCH;
            end
          end
          OP_ADDI: state_next = S_IMMEX;
`ifdef MC_BRANCH_EN
          OP_BEQ:  state_next = S_BRANCH;
`endif
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrc     = 1'b1;
        ALUControl = ALU_ADD;
        state_next = is_lw_reg ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        ALUSrc     = 1'b1;
        ALUControl = ALU_ADD;
        state_next = S_MEMWB;
      end

      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        MemWrite   = 1'b1;
        ALUSrc     = 1'b1;
        ALUControl = ALU_ADD;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_EXEC: begin
        ALUControl = alu_op_reg;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        ALUControl = alu_op_reg;
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_IMMEX: begin
        ALUSrc     = 1'b1;
        ALUControl = ALU_ADD;
        state_next = S_IMMWB;
      end

      S_IMMWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

`ifdef MC_BRANCH_EN
      S_BRANCH: begin
        ALUControl = ALU_SUB;
        pc_src     = 1'b1;
        pc_write   = zero_flag;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
`endif

      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: driver queues per-cycle expected output vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic [2:0] ALUControl;
  logic       RegWrite, MemWrite, ALUSrc, RegDst, MemtoReg;
  logic       ir_write, pc_write, pc_src, retire, illegal;

  mips_multicycle_control #(.ALU_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct(funct), .zero_flag(zero_flag), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Output vector layout: {ALUControl[2:0], RegWrite, MemWrite, ALUSrc, RegDst, MemtoReg,
  //                        ir_write, pc_write, pc_src, retire, illegal}
  localparam logic [12:0] RW  = 13'd1 << 9;
  localparam logic [12:0] MW  = 13'd1 << 8;
  localparam logic [12:0] AS  = 13'd1 << 7;
  localparam logic [12:0] RD  = 13'd1 << 6;
  localparam logic [12:0] M2R = 13'd1 << 5;
  localparam logic [12:0] IR  = 13'd1 << 4;
  localparam logic [12:0] PW  = 13'd1 << 3;
  localparam logic [12:0] PS  = 13'd1 << 2;
  localparam logic [12:0] RET = 13'd1 << 1;
  localparam logic [12:0] ILL = 13'd1;
  localparam logic [12:0] NONE = 13'd0;

  function automatic logic [12:0] alu(input logic [2:0] code);
    return {code, 10'b0};
  endfunction

  logic [12:0] act;
  assign act = {ALUControl, RegWrite, MemWrite, ALUSrc, RegDst, MemtoReg,
                ir_write, pc_write, pc_src, retire, illegal};

  logic [12:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          failures = 0;
  int          rw_pulses = 0;

  always @(posedge clk) begin
    if (RegWrite === 1'b1) rw_pulses++;
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", t, act, e);
      end else begin
        $display("ok   %s out=%b", t, act);
      end
    end
  end

  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic [12:0] e, input string t);
    @(posedge clk);
    #1;
    instr_valid = v;
    opcode      = op;
    funct       = fn;
    zero_flag   = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Cycle 1 is FETCH accept, cycle 2 DECODE; cycles 3..n use e3..e5, then one idle FETCH cycle.
  // instr_valid stays high after accept to show it is ignored outside FETCH.
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int n, input logic [12:0] e2,
                     input logic [12:0] e3, input logic [12:0] e4, input logic [12:0] e5);
    step(1'b1, op, fn, z, IR | PW, $sformatf("%s/c1", name));
    step(1'b1, op, fn, z, e2, $sformatf("%s/c2", name));
    if (n >= 3) step(1'b1, op, fn, z, e3, $sformatf("%s/c3", name));
    if (n >= 4) step(1'b1, op, fn, z, e4, $sformatf("%s/c4", name));
    if (n >= 5) step(1'b1, op, fn, z, e5, $sformatf("%s/c5", name));
    step(1'b0, op, fn, z, NONE, $sformatf("%s/idle", name));
  endtask

  initial begin
    int rw_before;

    rst_n       = 1'b0;
    instr_valid = 1'b1;
    opcode      = 6'b100011;
    funct       = 6'b000000;
    zero_flag   = 1'b0;

    // Held in reset with instr_valid high: nothing may assert.
    step(1'b1, 6'b100011, 6'b0, 1'b0, NONE, "reset/a");
    step(1'b1, 6'b100011, 6'b0, 1'b0, NONE, "reset/b");
    @(negedge clk); #1;
    rst_n = 1'b1;
    instr_valid = 1'b0;
    step(1'b0, 6'b100011, 6'b0, 1'b0, NONE, "post_reset");

    run("lw",    6'b100011, 6'b000000, 1'b0, 5, NONE, alu(3'b010) | AS, alu(3'b010) | AS, RW | M2R | RET);
    run("sw",    6'b101011, 6'b000000, 1'b0, 4, NONE, alu(3'b010) | AS, alu(3'b010) | AS | MW | RET, NONE);
    run("sub",   6'b000000, 6'b100010, 1'b0, 4, NONE, alu(3'b110), alu(3'b110) | RW | RD | RET, NONE);
    run("add",   6'b000000, 6'b100000, 1'b0, 4, NONE, alu(3'b010), alu(3'b010) | RW | RD | RET, NONE);
    run("and",   6'b000000, 6'b100100, 1'b0, 4, NONE, alu(3'b000), alu(3'b000) | RW | RD | RET, NONE);
    run("or",    6'b000000, 6'b100101, 1'b0, 4, NONE, alu(3'b001), alu(3'b001) | RW | RD | RET, NONE);
    run("slt",   6'b000000, 6'b101010, 1'b1, 4, NONE, alu(3'b111), alu(3'b111) | RW | RD | RET, NONE);
    run("addi",  6'b001000, 6'b000000, 1'b0, 4, NONE, alu(3'b010) | AS, RW | RET, NONE);
`ifdef MC_BRANCH_EN
    run("beq_z1", 6'b000100, 6'b000000, 1'b1, 3, NONE, alu(3'b110) | PS | PW | RET, NONE, NONE);
    run("beq_z0", 6'b000100, 6'b000000, 1'b0, 3, NONE, alu(3'b110) | PS | RET, NONE, NONE);
`else
    run("beq_off", 6'b000100, 6'b000000, 1'b1, 2, ILL, NONE, NONE, NONE);
`endif
    run("ill_op", 6'b111111, 6'b000000, 1'b0, 2, ILL, NONE, NONE, NONE);
    run("ill_fn", 6'b000000, 6'b000111, 1'b0, 2, ILL, NONE, NONE, NONE);

    for (int i = 0; i < 10; i++)
      step(1'b0, 6'(i * 7), 6'b100000, i[0], NONE, $sformatf("idle%0d", i));

    @(negedge clk); #1;
    checks++;
    if (act !== NONE) begin
        failures++;
        $display("FAIL idle_expired got=%b exp=%b", act, NONE);
    end else begin
        $display("ok   idle_expired out=%b", act);
    end

    // lw interrupted by reset while in MEMRD: no write-back, no retire.
    step(1'b1, 6'b100011, 6'b0, 1'b0, IR | PW, "lw_rst/c1");
    step(1'b1, 6'b100011, 6'b0, 1'b0, NONE, "lw_rst/c2");
    step(1'b1, 6'b100011, 6'b0, 1'b0, alu(3'b010) | AS, "lw_rst/c3");
    step(1'b1, 6'b100011, 6'b0, 1'b0, alu(3'b010) | AS, "lw_rst/c4");
    @(negedge clk); #1;
    rw_before = rw_pulses;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== NONE) begin
        failures++;
        $display("FAIL lw_rst/immediate got=%b exp=%b", act, NONE);
    end else begin
        $display("ok   lw_rst/immediate out=%b", act);
    end
    step(1'b1, 6'b100011, 6'b0, 1'b0, NONE, "lw_rst/in_reset_a");
    step(1'b1, 6'b100011, 6'b0, 1'b0, NONE, "lw_rst/in_reset_b");
    @(negedge clk); #1;
    rst_n = 1'b1;
    instr_valid = 1'b0;
    step(1'b0, 6'b100011, 6'b0, 1'b0, NONE, "lw_rst/after_a");
    step(1'b0, 6'b100011, 6'b0, 1'b0, NONE, "lw_rst/after_b");
    @(negedge clk); #1;
    checks++;
    if (rw_pulses != rw_before) begin
        failures++;
        $display("FAIL lw_rst/no_regwrite pulses=%0d exp=0", rw_pulses - rw_before);
    end else begin
        $display("ok   lw_rst/no_regwrite pulses=0");
    end

    run("add_after_rst", 6'b000000, 6'b100000, 1'b0, 4, NONE, alu(3'b010), alu(3'b010) | RW | RD | RET, NONE);

    @(posedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
